// File: rtl/count_arbiter.sv
// count_arbiter: round-robin sharing of one CW-bit event counter among NSRC
// event sources. Each source queues events in a small saturating pending
// counter. At most one increment per cycle goes to the shared counter. A clear
// request takes one cycle and blocks any grant in that cycle.
module count_arbiter #(
  parameter int NSRC   = 4,
  parameter int PEND_W = 2,
  parameter int CW     = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] evt,
  input  logic            clr_req,
  input  logic [CW-1:0]   cnt_q,
  output logic            cnt_incr,
  output logic            cnt_rst,
  output logic [NSRC-1:0] grant,
  output logic [NSRC-1:0] drop,
  output logic            wrap,
  output logic            busy
);

  localparam int PTR_W = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(NSRC - 1);

  logic [PEND_W-1:0] pend [NSRC];
  logic [PTR_W-1:0]  ptr;
  logic              sel_valid;
  logic [PTR_W-1:0]  sel;
  logic              issue;

  // Pick the first source with pending events, starting the search at ptr.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so
    // no path leaves it unassigned and no latch is inferred.
    sel_valid = 1'b0;
    sel       = '0;
    for (int k = 0; k < NSRC; k++) begin
      logic [PTR_W-1:0] idx;
      idx = PTR_W'((int'(ptr) + k) % NSRC);
      if (!sel_valid && pend[idx] != '0) begin
        sel_valid = 1'b1;
        sel       = idx;
      end
    end
  end

  // A clear request takes this cycle's slot, so no grant is issued.
  assign issue = sel_valid && !clr_req;

  // Grant, clear, wrap and pending bookkeeping, all registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the pending array is small and must read as empty after reset,
      // so each entry is cleared explicitly.
      for (int i = 0; i < NSRC; i++) pend[i] <= '0;
      ptr      <= '0;
      cnt_incr <= 1'b0;
      cnt_rst  <= 1'b0;
      grant    <= '0;
      drop     <= '0;
      wrap     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples
      // pre-edge values no matter what order the statements are in.
      cnt_rst  <= clr_req;
      cnt_incr <= issue;
      // The counter rolls over on the same edge that consumes an incr at max.
      wrap     <= cnt_incr && (cnt_q == '1);
      if (issue) begin
        grant <= NSRC'(1) << sel;
        ptr   <= (sel == PTR_LAST) ? '0 : sel + 1'b1;
      end else begin
        grant <= '0;
      end
      for (int i = 0; i < NSRC; i++) begin
        drop[i] <= 1'b0;
        if (evt[i] && !(issue && sel == PTR_W'(i))) begin
          if (pend[i] == PEND_MAX) drop[i] <= 1'b1;
          else                     pend[i] <= pend[i] + 1'b1;
        end else if (!evt[i] && issue && sel == PTR_W'(i)) begin
          pend[i] <= pend[i] - 1'b1;
        end
      end
    end
  end

  // Busy while any event is still queued or an increment is in flight.
  always_comb begin
    busy = cnt_incr;
    for (int i = 0; i < NSRC; i++) begin
      if (pend[i] != '0) busy = 1'b1;
    end
  end

endmodule

// File: doc/count_arbiter.md
# count_arbiter

Round-robin arbiter that shares one 8-bit event counter (clk/incr/rst, count output q) among NSRC event sources. Each source pulses an event, and the block queues it in a small per-source pending counter. It then issues at most one increment per cycle to the shared counter and also drives the counter's clear. The block sits between the event-producing logic and the counter, and reports grants, dropped events and counter wrap.

## Interface
- NSRC, 4, number of event sources (2..8)
- PEND_W, 2, pending-counter width per source; max pending = 2^PEND_W-1
- CW, 8, width of the shared counter's q
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- evt  in  NSRC  one-cycle event pulse per source
- clr_req  in  1  request to clear the shared counter
- cnt_q  in  CW  current value of the shared counter
- cnt_incr  out  1  increment strobe to counter (registered)
- cnt_rst  out  1  clear strobe to counter (registered), ORed with rst at counter
- grant  out  NSRC  one-hot, source serviced by current cnt_incr (registered)
- drop  out  NSRC  one-cycle pulse, event lost because pending full
- wrap  out  1  one-cycle pulse, counter rolled over 2^CW-1 -> 0
- busy  out  1  any pending count nonzero or cnt_incr high

## Operation
- State: pend[i] (PEND_W bits) per source, round-robin pointer ptr (clog2 NSRC bits), registered outputs.
- Selection (combinational, from registered pend and ptr): first i with pend[i]!=0 searching ptr, ptr+1, ... modulo NSRC. If none, no grant.
- Each edge, when no clear is being issued: if a source is selected, then grant<=onehot(sel), cnt_incr<=1, ptr<=(sel+1) mod NSRC. Otherwise grant<=0, cnt_incr<=0, ptr unchanged.
- Pending update per source: pend[i] <= pend[i] + evt[i] - (selected==i).
  - Simultaneous event and grant on one source leaves pend unchanged.
  - If pend[i]==max, evt[i]=1 and i is not selected, then pend stays max and drop[i]<=1.
- Clear: clr_req=1 at an edge makes cnt_rst<=1 and forces cnt_incr<=0 and grant<=0 for that cycle.
  - ptr is unchanged and no pending count is decremented.
  - Events arriving in that cycle still accumulate (or drop).
  - Pending counts survive the clear and are issued afterward.
- cnt_rst and cnt_incr are never high in the same cycle.
- Wrap: wrap<=1 at the edge where cnt_incr==1 and cnt_q==2^CW-1, i.e. the same edge where the counter goes to 0.
- Reset: pend=0, ptr=0, cnt_incr=0, cnt_rst=0, grant=0, drop=0, wrap=0, busy=0.
  - Reset mid-operation discards all pending events without drop pulses.
  - rst has priority over clr_req and evt.

## Timing
- evt[i] high in cycle t: pend[i] nonzero from t+1. Earliest grant[i]/cnt_incr is high in cycle t+2, and cnt_q shows the increment in t+3.
- Throughput: one increment per cycle while any pend nonzero. N queued events from one source need N consecutive cycles.
- clr_req in cycle t: cnt_rst high in t+1, cnt_q=0 in t+2. A clear costs one grant slot.
- drop and wrap are single-cycle pulses, registered, visible the cycle after the causing edge.
- busy is combinational from registered state: OR of pend[i]!=0 and cnt_incr.
- All inputs sampled at the rising edge only; no combinational input-to-output paths except through busy's state terms.

## Test plan
- Reset then a single evt[2] at cycle 5:
  - grant=4'b0100 and cnt_incr=1 in cycle 7 only.
  - cnt_q goes 0->1 in cycle 8.
  - busy high cycles 6-7.
- evt=4'b1111 in one cycle:
  - grants 0001,0010,0100,1000 in four consecutive cycles from ptr=0.
  - cnt_q=4, then ptr=0.
- evt[1] held high for 6 cycles with evt[0] pending continuously:
  - grants alternate 0001/0010.
  - No drop on source 1, since grant and event cancel.
  - With other sources saturating, drop[1] pulses once per excess event beyond 3 pending.
- Preload so cnt_q=255, one evt[0]: cnt_incr with cnt_q=255 gives wrap=1 the next cycle, cnt_q=0.
- Three events pending on source 3, clr_req pulsed when the first grant would issue:
  - cnt_rst high one cycle, no grant that cycle.
  - Then three grant=1000 cycles, final cnt_q=3.
- rst asserted with pend=3 on two sources: all outputs 0 next cycle, no further grants, no drop pulses.
